// File: rtl/param_right_rotator_pipe.sv
// Pipelined right barrel rotator: N registered stages, stage i rotates right by 2**i.
// Global-stall valid/ready pipeline with registered outputs and full throughput.
module param_right_rotator_pipe #(
    parameter int unsigned N = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [(2**N)-1:0]   in_data,
    input  logic [N-1:0]        in_amount,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [(2**N)-1:0]   out_data
);

    localparam int unsigned W = 2 ** N;

    logic adv;

    for (genvar g = 0; g < N; g++) begin : g_stage
        // Amount bits still to be applied when entering this stage.
        localparam int unsigned AW = N - g;
        localparam int unsigned Sh = 2 ** g;

        logic [W-1:0]  src_data;
        logic [AW-1:0] src_amt;
        logic          src_valid;
        logic [W-1:0]  rot;
        logic [W-1:0]  data_q;
        logic          valid_q;

        if (g == 0) begin : g_src
            assign src_data  = in_data;
            assign src_amt   = in_amount;
            assign src_valid = in_valid;
        end else begin : g_src
            assign src_data  = g_stage[g-1].data_q;
            assign src_amt   = g_stage[g-1].g_amt.amt_q;
            assign src_valid = g_stage[g-1].valid_q;
        end

        assign rot = (src_data >> Sh) | (src_data << (W - Sh));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (adv) begin
                data_q  <= src_amt[0] ? rot : src_data;
                valid_q <= src_valid;
            end
        end

        // Only the not-yet-consumed amount bits travel on; the last stage needs none.
        if (AW > 1) begin : g_amt
            logic [AW-2:0] amt_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    amt_q <= '0;
                end else if (adv) begin
                    amt_q <= src_amt[AW-1:1];
                end
            end
        end
    end

    assign adv       = !g_stage[N-1].valid_q || out_ready;
    assign in_ready  = reset_n && adv;
    assign out_valid = g_stage[N-1].valid_q;
    assign out_data  = g_stage[N-1].data_q;

endmodule

// File: tb/tb_param_right_rotator_pipe.sv
// Scoreboard bench for param_right_rotator_pipe at N=3: expectations queued on accept,
// compared on output handshake, with latency, backpressure and reset checks.
module tb_param_right_rotator_pipe;

    localparam int unsigned N = 3;
    localparam int unsigned W = 8;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b1;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic [N-1:0] in_amount = '0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;

    typedef struct {
        logic [W-1:0] data;
        int           stamp;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    bit   lat_chk = 1'b1;

    param_right_rotator_pipe #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rotr(input logic [W-1:0] d, input logic [N-1:0] a);
        logic [2*W-1:0] x;
        x = {d, d};
        return x[a +: W];
    endfunction

    // Drive one word and hold it until accepted; the expectation is queued at acceptance.
    task automatic send(input logic [W-1:0] d, input logic [N-1:0] a, input logic [W-1:0] exp);
        int   guard;
        exp_t e;
        guard     = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = a;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.data  = exp;
            e.stamp = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            check("out_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                if (lat_chk) check("latency", 32'(cyc - e.stamp), 32'd3);
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        logic [N-1:0] a;
        logic [W-1:0] held;

        // Asynchronous reset before any clock edge.
        #3 reset_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        #18 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single word and directed values, including passthrough and left-by-one boundaries.
        send(8'h81, 3'd1, 8'hC0);
        drain();
        send(8'hB4, 3'd3, 8'h96);
        send(8'h01, 3'd7, 8'h02);
        send(8'h5A, 3'd0, 8'h5A);
        send(8'hF0, 3'd4, 8'h0F);
        drain();

        // Back-to-back stream with random amounts.
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom_range(0, 255));
            a = 3'($urandom_range(0, 7));
            send(d, a, rotr(d, a));
        end
        drain();

        // Backpressure: fill the pipeline, stall four cycles, then release.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        held      = rotr(8'h3C, 3'd2);
        send(8'h3C, 3'd2, held);
        send(8'hA5, 3'd5, rotr(8'hA5, 3'd5));
        send(8'h17, 3'd6, rotr(8'h17, 3'd6));
        fork
            send(8'hE2, 3'd1, rotr(8'hE2, 3'd1));
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_out_valid", 32'(out_valid), 32'd1);
                    check("bp_out_data", 32'(out_data), 32'(held));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        send(8'h6B, 3'd3, rotr(8'h6B, 3'd3));
        send(8'hC9, 3'd7, rotr(8'hC9, 3'd7));
        drain();
        lat_chk = 1'b1;

        // Reset mid-stream with three words in flight.
        send(8'hFF, 3'd0, 8'hFF);
        send(8'h7E, 3'd2, rotr(8'h7E, 3'd2));
        send(8'hD3, 3'd5, rotr(8'hD3, 3'd5));
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'h00);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(8'h81, 3'd1, 8'hC0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
